// File: rtl/swerv_types.sv
// swerv_types: trigger packet, trigger CSR addresses and mtdata1 bit positions.
package swerv_types;
    localparam logic [11:0] MTSEL = 12'h7A0;
    localparam logic [11:0] MTDATA1 = 12'h7A1;
    localparam logic [11:0] MTDATA2 = 12'h7A2;
    localparam logic [3:0] MT_TYPE = 4'h2;
    localparam int MT_DMODE = 27;
    localparam int MT_HIT = 20;
    localparam int MT_SELECT = 19;
    localparam int MT_ACTION = 12;
    localparam int MT_CHAIN = 11;
    localparam int MT_MATCH = 7;
    localparam int MT_M = 6;
    localparam int MT_EXECUTE = 2;
    localparam int MT_STORE = 1;
    localparam int MT_LOAD = 0;
    typedef struct packed {
        logic select;
        logic match;
        logic store;
        logic load;
        logic execute;
        logic m;
        logic [31:0] tdata2;
    } trigger_pkt_t;
    typedef struct packed {
        logic dmode;
        logic hit;
        logic select;
        logic action;
        logic chain;
        logic match;
        logic m;
        logic execute;
        logic store;
        logic load;
    } mtdata1_t;
    function automatic logic [31:0] mtdata1_pack(mtdata1_t t);
        logic [31:0] r;
        r = '0;
        r[31:28] = MT_TYPE;
        r[MT_DMODE] = t.dmode;
        r[MT_HIT] = t.hit;
        r[MT_SELECT] = t.select;
        r[MT_ACTION] = t.action;
        r[MT_CHAIN] = t.chain;
        r[MT_MATCH] = t.match;
        r[MT_M] = t.m;
        r[MT_EXECUTE] = t.execute;
        r[MT_STORE] = t.store;
        r[MT_LOAD] = t.load;
        return r;
    endfunction
    function automatic mtdata1_t mtdata1_unpack(logic [31:0] w);
        mtdata1_t t;
        t.dmode = w[MT_DMODE];
        t.hit = w[MT_HIT];
        t.select = w[MT_SELECT];
        t.action = w[MT_ACTION];
        t.chain = w[MT_CHAIN];
        t.match = w[MT_MATCH];
        t.m = w[MT_M];
        t.execute = w[MT_EXECUTE];
        t.store = w[MT_STORE];
        t.load = w[MT_LOAD];
        return t;
    endfunction
endpackage

// File: rtl/dec_trigger_chain.sv
// dec_trigger_chain: pairwise chain resolver; RV_TRIGGER_CHAIN_EN enables chaining, otherwise match passes through.
module dec_trigger_chain #(
    parameter int NUM_TRIG = 4
) (
    input  logic [NUM_TRIG-1:0] match_in,
    input  logic [NUM_TRIG-1:0] chain,
    output logic [NUM_TRIG-1:0] match_out
);
`ifdef RV_TRIGGER_CHAIN_EN
    always_comb begin
        match_out = match_in;
        for (int k = 0; k < NUM_TRIG; k += 2) begin
            if (chain[k]) begin
                match_out[k] = match_in[k] & match_in[k+1];
                match_out[k+1] = match_in[k] & match_in[k+1];
            end
        end
    end
`else
    logic unused_chain;
    assign unused_chain = ^chain;
    assign match_out = match_in;
`endif
endmodule

// File: rtl/dec_trigger_csr.sv
// dec_trigger_csr: debug trigger CSRs, match qualification, sticky hits and registered fire/action requests.
// RV_TRIGGER_CHAIN_EN enables pairwise chaining of triggers (2k, 2k+1).
module dec_trigger_csr
    import swerv_types::*;
#(
    parameter int NUM_TRIG = 4,
    parameter int TD_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          csr_wen,
    input  logic                          csr_ren,
    input  logic [11:0]                   csr_addr,
    input  logic [31:0]                   csr_wdata,
    output logic [31:0]                   csr_rdata,
    output logic                          csr_hit,
    input  logic                          dbg_mode,
    input  logic                          dec_i0_valid_d,
    input  logic                          dec_i1_valid_d,
    input  logic [NUM_TRIG-1:0]           dec_i0_trigger_match_d,
    input  logic [NUM_TRIG-1:0]           dec_i1_trigger_match_d,
    output trigger_pkt_t [NUM_TRIG-1:0]   trigger_pkt_any,
    output logic [NUM_TRIG-1:0]           trig_fire_i0_e1,
    output logic [NUM_TRIG-1:0]           trig_fire_i1_e1,
    output logic                          trig_dbg_req_e1,
    output logic                          trig_bkpt_e1
);
`ifdef RV_TRIGGER_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif
    logic [1:0] mtsel_q, mtsel_d;
    mtdata1_t [NUM_TRIG-1:0] mtd1_q, mtd1_d;
    logic [NUM_TRIG-1:0][TD_W-1:0] td2_q, td2_d;
    logic [NUM_TRIG-1:0] chain, action, res_i0, res_i1, fire_i0_d, fire_i1_d, fire_any;
    logic [NUM_TRIG-1:0] fire_i0_q, fire_i1_q;
    logic dbg_req_d, dbg_req_q, bkpt_d, bkpt_q;
    logic locked, wr_sel, wr_d1, wr_d2, unused_wdata;

    assign unused_wdata = ^csr_wdata;
    assign locked = mtd1_q[mtsel_q].dmode && !dbg_mode;
    assign wr_sel = csr_wen && csr_addr == MTSEL;
    assign wr_d1 = csr_wen && csr_addr == MTDATA1 && !locked;
    assign wr_d2 = csr_wen && csr_addr == MTDATA2 && !locked;

    dec_trigger_chain #(.NUM_TRIG(NUM_TRIG)) u_chain_i0 (
        .match_in(dec_i0_trigger_match_d), .chain(chain), .match_out(res_i0));
    dec_trigger_chain #(.NUM_TRIG(NUM_TRIG)) u_chain_i1 (
        .match_in(dec_i1_trigger_match_d), .chain(chain), .match_out(res_i1));

    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            chain[i] = mtd1_q[i].chain;
            action[i] = mtd1_q[i].action;
        end
        fire_i0_d = res_i0 & {NUM_TRIG{dec_i0_valid_d}};
        fire_i1_d = res_i1 & {NUM_TRIG{dec_i1_valid_d}};
        fire_any = fire_i0_d | fire_i1_d;
        dbg_req_d = |(fire_any & action);
        bkpt_d = |(fire_any & ~action);
    end

    // A fire on the same cycle as a hit-clearing write keeps hit set.
    always_comb begin
        mtsel_d = wr_sel ? csr_wdata[1:0] : mtsel_q;
        mtd1_d = mtd1_q;
        td2_d = td2_q;
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (wr_d1 && mtsel_q == 2'(i)) begin
                mtd1_d[i] = mtdata1_unpack(csr_wdata);
                mtd1_d[i].dmode = dbg_mode ? csr_wdata[MT_DMODE] : mtd1_q[i].dmode;
                mtd1_d[i].chain = CHAIN_EN && (i % 2 == 0) && csr_wdata[MT_CHAIN];
                mtd1_d[i].hit = mtd1_q[i].hit && csr_wdata[MT_HIT];
            end
            if (wr_d2 && mtsel_q == 2'(i)) td2_d[i] = TD_W'(csr_wdata);
            mtd1_d[i].hit = mtd1_d[i].hit | fire_any[i];
        end
    end

    always_comb begin
        csr_hit = csr_addr == MTSEL || csr_addr == MTDATA1 || csr_addr == MTDATA2;
        csr_rdata = !csr_ren ? '0 :
                    csr_addr == MTSEL ? {30'b0, mtsel_q} :
                    csr_addr == MTDATA1 ? mtdata1_pack(mtd1_q[mtsel_q]) :
                    csr_addr == MTDATA2 ? 32'(td2_q[mtsel_q]) : '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            trigger_pkt_any[i].select = mtd1_q[i].select;
            trigger_pkt_any[i].match = mtd1_q[i].match;
            trigger_pkt_any[i].store = mtd1_q[i].store;
            trigger_pkt_any[i].load = mtd1_q[i].load;
            trigger_pkt_any[i].execute = mtd1_q[i].execute;
            trigger_pkt_any[i].m = mtd1_q[i].m;
            trigger_pkt_any[i].tdata2 = 32'(td2_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtsel_q <= '0;
            mtd1_q <= '0;
            td2_q <= '0;
            fire_i0_q <= '0;
            fire_i1_q <= '0;
            dbg_req_q <= 1'b0;
            bkpt_q <= 1'b0;
        end else begin
            mtsel_q <= mtsel_d;
            mtd1_q <= mtd1_d;
            td2_q <= td2_d;
            fire_i0_q <= fire_i0_d;
            fire_i1_q <= fire_i1_d;
            dbg_req_q <= dbg_req_d;
            bkpt_q <= bkpt_d;
        end
    end

    assign trig_fire_i0_e1 = fire_i0_q;
    assign trig_fire_i1_e1 = fire_i1_q;
    assign trig_dbg_req_e1 = dbg_req_q;
    assign trig_bkpt_e1 = bkpt_q;
endmodule

// File: tb/tb_dec_trigger_csr.sv
// tb_dec_trigger_csr: scoreboard bench for dec_trigger_csr against a word-level CSR model.
module tb_dec_trigger_csr;
    import swerv_types::*;
`ifdef RV_TRIGGER_CHAIN_EN
    localparam bit CH = 1'b1;
`else
    localparam bit CH = 1'b0;
`endif
    localparam int N = 4;
    localparam logic [31:0] HIT = 32'h0010_0000;
    typedef trigger_pkt_t [N-1:0] pkts_t;

    logic clk = 1'b1;
    logic rst, csr_wen, csr_ren, dbg_mode, v0, v1, chit, dreq, bkpt;
    logic [11:0] addr;
    logic [31:0] wdata, rdata;
    logic [N-1:0] m0, m1, f0, f1;
    pkts_t pkt;
    int checks = 0;
    int failures = 0;

    bit [1:0] sel;
    bit [31:0] w[N];
    bit [31:0] td2[N];
    pkts_t pk_q[$];
    bit [32:0] rd_q[$];
    bit [2*N+1:0] e1_q[$];
    logic [11:0] addrs[5] = '{12'h7A0, 12'h7A1, 12'h7A2, 12'h7A3, 12'h300};

    always #5 clk = ~clk;

    dec_trigger_csr #(.NUM_TRIG(N), .TD_W(32)) dut (
        .clk(clk), .rst(rst), .csr_wen(csr_wen), .csr_ren(csr_ren), .csr_addr(addr),
        .csr_wdata(wdata), .csr_rdata(rdata), .csr_hit(chit), .dbg_mode(dbg_mode),
        .dec_i0_valid_d(v0), .dec_i1_valid_d(v1),
        .dec_i0_trigger_match_d(m0), .dec_i1_trigger_match_d(m1),
        .trigger_pkt_any(pkt), .trig_fire_i0_e1(f0), .trig_fire_i1_e1(f1),
        .trig_dbg_req_e1(dreq), .trig_bkpt_e1(bkpt));

    task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Chained pair fires only when both members match in the same slot.
    function automatic bit [N-1:0] resolve(bit [N-1:0] m);
        bit [N-1:0] r;
        for (int i = 0; i < N; i++)
            r[i] = (CH && w[i & ~1][11]) ? (m[i] && m[i ^ 1]) : m[i];
        return r;
    endfunction

    always @(negedge clk) begin
        if (pk_q.size() > 0) chk("trigger_pkt_any", 160'(pkt), 160'(pk_q.pop_front()));
        if (rd_q.size() > 0) chk("csr_hit_rdata", 160'({chit, rdata}), 160'(rd_q.pop_front()));
        if (e1_q.size() >= 2) chk("fire_e1", 160'({f0, f1, dreq, bkpt}), 160'(e1_q.pop_front()));
    end

    task automatic step(bit r, bit we, bit re, bit [11:0] a, bit [31:0] wd, bit dm,
                        bit iv0, bit [N-1:0] im0, bit iv1, bit [N-1:0] im1);
        bit [N-1:0] e0, e1v, fa;
        bit dq, bk, lock;
        bit [31:0] rd, mask;
        pkts_t ep;
        rst = r; csr_wen = we; csr_ren = re; addr = a; wdata = wd; dbg_mode = dm;
        v0 = iv0; m0 = im0; v1 = iv1; m1 = im1;
        for (int i = 0; i < N; i++) begin
            ep[i].select = w[i][19];
            ep[i].match = w[i][7];
            ep[i].store = w[i][1];
            ep[i].load = w[i][0];
            ep[i].execute = w[i][2];
            ep[i].m = w[i][6];
            ep[i].tdata2 = td2[i];
        end
        pk_q.push_back(ep);
        rd = !re ? 32'h0 : a == 12'h7A0 ? {30'b0, sel} : a == 12'h7A1 ? (w[sel] | 32'h2000_0000) :
             a == 12'h7A2 ? td2[sel] : 32'h0;
        rd_q.push_back({a == 12'h7A0 || a == 12'h7A1 || a == 12'h7A2, rd});
        e0 = iv0 ? resolve(im0) : '0;
        e1v = iv1 ? resolve(im1) : '0;
        fa = e0 | e1v;
        dq = 0;
        bk = 0;
        for (int i = 0; i < N; i++) if (fa[i]) begin
            if (w[i][12]) dq = 1;
            else bk = 1;
        end
        e1_q.push_back(r ? '0 : {e0, e1v, dq, bk});
        @(posedge clk);
        if (r) begin
            sel = 0;
            for (int i = 0; i < N; i++) begin
                w[i] = 0;
                td2[i] = 0;
            end
        end else begin
            lock = w[sel][27] && !dm;
            mask = 32'h0008_10C7 | ((CH && !sel[0]) ? 32'h800 : 32'h0) | (dm ? 32'h0800_0000 : 32'h0);
            if (we && a == 12'h7A1 && !lock)
                w[sel] = (w[sel] & ~mask & ~HIT) | (wd & mask) | (w[sel] & wd & HIT);
            if (we && a == 12'h7A2 && !lock) td2[sel] = wd;
            for (int i = 0; i < N; i++) if (fa[i]) w[i] = w[i] | HIT;
            if (we && a == 12'h7A0) sel = wd[1:0];
        end
        #1;
    endtask

    task automatic wr(bit [11:0] a, bit [31:0] d, bit dm);
        step(0, 1, 0, a, d, dm, 0, '0, 0, '0);
    endtask

    task automatic rd(bit [11:0] a);
        step(0, 0, 1, a, 32'h0, 0, 0, '0, 0, '0);
    endtask

    task automatic go(bit iv0, bit [N-1:0] im0, bit iv1, bit [N-1:0] im1);
        step(0, 0, 0, 12'h0, 32'h0, 0, iv0, im0, iv1, im1);
    endtask

    initial begin
        rst = 1; csr_wen = 0; csr_ren = 0; addr = 0; wdata = 0; dbg_mode = 0;
        v0 = 0; v1 = 0; m0 = 0; m1 = 0;
        sel = 0;
        for (int i = 0; i < N; i++) begin
            w[i] = 0;
            td2[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rd(12'h7A1);
        rd(12'h7A0);
        wr(12'h7A0, 32'h1, 0);
        wr(12'h7A2, 32'h8000_0100, 0);
        wr(12'h7A1, 32'h0000_0004, 0);
        go(1, 4'b0010, 0, 4'b0000);
        rd(12'h7A1);
        rd(12'h7A2);
        wr(12'h7A0, 32'h0, 0);
        wr(12'h7A1, 32'h0000_1800, 0);
        go(1, 4'b0001, 0, 4'b0000);
        go(1, 4'b0011, 0, 4'b0000);
        go(0, 4'b0000, 0, 4'b0000);
        rd(12'h7A1);
        wr(12'h7A0, 32'h2, 1);
        wr(12'h7A1, 32'h0800_0004, 1);
        wr(12'h7A2, 32'hFFFF_FFFF, 0);
        rd(12'h7A2);
        rd(12'h7A1);
        wr(12'h7A0, 32'h3, 0);
        go(1, 4'b1000, 0, 4'b0000);
        step(0, 1, 0, 12'h7A1, 32'h0, 0, 0, 4'b0000, 1, 4'b1000);
        rd(12'h7A1);
        wr(12'h7A1, 32'h0, 0);
        rd(12'h7A1);
        go(0, 4'b0100, 0, 4'b0100);
        wr(12'h7A0, 32'h2, 0);
        rd(12'h7A1);
        step(1, 0, 0, 12'h0, 32'h0, 0, 1, 4'b1111, 1, 4'b1111);
        go(0, 4'b0000, 0, 4'b0000);
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                 addrs[$urandom_range(0, 4)], $urandom, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom));
        go(0, 4'b0000, 0, 4'b0000);
        go(0, 4'b0000, 0, 4'b0000);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
